// File: rtl/counter_pkg.sv
// Shared definitions for the up/down sweep controller and its counter core:
// controller state encodings and direction constants.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/updown_count_core.sv
// WIDTH-bit up/down counter register. A load overrides stepping; otherwise
// en moves the count by one in the direction given by dir (modulo 2^WIDTH).
module updown_count_core
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  // Counter register: synchronous reset, then load, then single step.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= (dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule : updown_count_core

// File: rtl/updown_sweep_ctrl.sv
// Command-driven sweep controller: accepts one command per valid/ready
// handshake, steps the counter core N times between latched limits and
// pulses done on completion.
// Build option SWEEP_BOUNCE_EN: defined -> direction reverses at a limit and
// stepping continues (ping-pong); undefined -> count saturates at the limit
// and the command ends early.
module updown_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int STEPS_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic [WIDTH-1:0]   lo_limit,
  input  logic [WIDTH-1:0]   hi_limit,
  input  logic               hold,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               limit_hit
);

  state_t             state, state_nxt;
  logic [STEPS_W-1:0] remaining;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic               dir_q, err_q, hit_q;

  logic               accept, cmd_bad, cmd_zero, step;
  logic               below, above, pinned, step_hit, step_last, early_stop;
  logic [WIDTH-1:0]   step_val;
  logic               core_en, core_load;

  assign accept   = cmd_valid & cmd_ready;
  assign cmd_bad  = lo_limit > hi_limit;
  assign cmd_zero = (cmd_steps == '0);
  assign step     = (state == ST_RUN) && !hold;

  // Step datapath: where this step lands and whether that is a limit.
  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    below     = count < lo_q;
    above     = count > hi_q;
    pinned    = ((dir_q == DIR_UP) && (count == hi_q)) ||
                ((dir_q == DIR_DOWN) && (count == lo_q));
    step_val  = count;
    core_en   = 1'b0;
    core_load = 1'b0;
    if (below) begin
      step_val = lo_q;
    end else if (above) begin
      step_val = hi_q;
    end else if (pinned) begin
      step_val = count;
    end else begin
      step_val = (dir_q == DIR_UP) ? count + 1'b1 : count - 1'b1;
    end
    if (step) begin
      if (below || above || pinned) core_load = 1'b1;
      else                          core_en   = 1'b1;
    end
  end

  assign step_hit  = ((dir_q == DIR_UP) && (step_val == hi_q)) ||
                     ((dir_q == DIR_DOWN) && (step_val == lo_q));
  assign step_last = (remaining == STEPS_W'(1));
`ifdef SWEEP_BOUNCE_EN
  assign early_stop = 1'b0;
`else
  assign early_stop = step_hit;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = (cmd_zero || cmd_bad) ? ST_DONE : ST_RUN;
      ST_RUN:  if (step && (step_last || early_stop)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latches, step budget, direction and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      dir_q     <= DIR_UP;
      err_q     <= 1'b0;
      hit_q     <= 1'b0;
    end else if (accept) begin
      remaining <= cmd_steps;
      lo_q      <= lo_limit;
      hi_q      <= hi_limit;
      dir_q     <= cmd_dir;
      err_q     <= cmd_bad;
      hit_q     <= 1'b0;
    end else if (step) begin
      remaining <= remaining - 1'b1;
      if (step_hit) begin
        hit_q <= 1'b1;
`ifdef SWEEP_BOUNCE_EN
        dir_q <= ~dir_q;
`endif
      end
    end
  end

  updown_count_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (core_en),
    .dir      (dir_q),
    .load     (core_load),
    .load_val (step_val),
    .count    (count)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign dir       = dir_q;
  assign err       = err_q;
  assign limit_hit = hit_q;

endmodule : updown_sweep_ctrl

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl: an integer-level model of the
// sweep rules checked every cycle, plus hand-computed literal expectations.
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b1;
  logic [7:0] cmd_steps = '0;
  logic [3:0] lo_limit = '0;
  logic [3:0] hi_limit = '0;
  logic       hold = 1'b0;
  logic [3:0] count;
  logic       dir, busy, done, err, limit_hit;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  updown_sweep_ctrl #(.WIDTH(4), .STEPS_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .lo_limit  (lo_limit),
    .hi_limit  (hi_limit),
    .hold      (hold),
    .count     (count),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .limit_hit (limit_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, one update per rising edge.
  int m_count = 0, m_left = 0, m_lo = 0, m_hi = 0;
  bit m_dir = 1, m_busy = 0, m_done = 0, m_err = 0, m_hit = 0;

  always @(posedge clk) begin
    bit reached;
    if (reset) begin
      m_count = 0; m_dir = 1; m_left = 0;
      m_busy = 0; m_done = 0; m_err = 0; m_hit = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_lo = int'(lo_limit); m_hi = int'(hi_limit);
        m_left = int'(cmd_steps); m_dir = cmd_dir;
        m_hit = 0;
        m_err = (m_lo > m_hi);
        if (m_err || m_left == 0) m_done = 1;
        else                      m_busy = 1;
      end
    end else if (!hold) begin
      if (m_count < m_lo)      m_count = m_lo;
      else if (m_count > m_hi) m_count = m_hi;
      else if (m_dir)          m_count = (m_count + 1 > m_hi) ? m_hi : m_count + 1;
      else                     m_count = (m_count - 1 < m_lo) ? m_lo : m_count - 1;
      m_left--;
      reached = m_dir ? (m_count == m_hi) : (m_count == m_lo);
      if (reached) m_hit = 1;
`ifdef SWEEP_BOUNCE_EN
      if (reached) m_dir = !m_dir;
      if (m_left == 0) begin m_busy = 0; m_done = 1; end
`else
      if (m_left == 0 || reached) begin m_busy = 0; m_done = 1; end
`endif
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", int'(count), m_count);
      check("dir", int'(dir), int'(m_dir));
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      check("cmd_ready", int'(cmd_ready), int'(!m_busy && !m_done));
      check("err", int'(err), int'(m_err));
      check("limit_hit", int'(limit_hit), int'(m_hit));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for ready, then presents one command for one edge.
  task automatic issue(input bit d, input int n, input int lo, input int hi);
    int guard = 0;
    while (!cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("ready_before_issue", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_dir = d;
    cmd_steps = 8'(n); lo_limit = 4'(lo); hi_limit = 4'(hi);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd();
    int guard = 0;
    while (!cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("cmd_completes", int'(cmd_ready), 1);
  endtask

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    reset = 1'b0;
    check("reset_count", int'(count), 0);
    check("reset_dir", int'(dir), 1);
    tick();
    check("ready_after_reset", int'(cmd_ready), 1);

    // 1: plain up sweep, with a stray command while busy
    issue(1, 5, 0, 15);
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) cmd_valid = 1'b1;
      if (k == 3) cmd_valid = 1'b0;
      tick();
      check("t1_count", int'(count), k);
    end
    check("t1_done", int'(done), 1);
    check("t1_hit", int'(limit_hit), 0);
    tick();

    // 2: reach 13, then sweep into the upper limit
    issue(1, 8, 0, 15);
    finish_cmd();
    check("t2_start", int'(count), 13);
    issue(1, 5, 0, 15);
    tick(); check("t2_s1", int'(count), 14);
    tick(); check("t2_s2", int'(count), 15);
`ifdef SWEEP_BOUNCE_EN
    tick(); check("t2_s3", int'(count), 14);
    tick(); check("t2_s4", int'(count), 13);
    tick(); check("t2_s5", int'(count), 12);
    check("t2_dir", int'(dir), 0);
`else
    check("t2_dir", int'(dir), 1);
`endif
    check("t2_done", int'(done), 1);
    check("t2_hit", int'(limit_hit), 1);
    tick();

    // 3: zero-step command
    issue(0, 0, 0, 15);
    check("t3_done", int'(done), 1);
    check("t3_err", int'(err), 0);
    tick();
    check("t3_ready", int'(cmd_ready), 1);

    // lo==hi: single step lands on the limit (2)
    issue(1, 1, 2, 2);
    tick();
    check("eq_count", int'(count), 2);
    check("eq_hit", int'(limit_hit), 1);
    tick();

    // 4: hold for three cycles after the first step
    issue(1, 4, 0, 15);
    tick(); check("t4_s1", int'(count), 3);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_hold", int'(count), 3);
    end
    hold = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      tick();
      check("t4_run", int'(count), k);
    end
    check("t4_done", int'(done), 1);
    tick();

    // 5: lo > hi rejected
    issue(1, 4, 9, 3);
    check("t5_done", int'(done), 1);
    check("t5_err", int'(err), 1);
    check("t5_count", int'(count), 6);
    tick();

    // clamp from below the window, then from above it
    issue(0, 3, 8, 12);
    tick(); check("clamp_lo", int'(count), 8);
    finish_cmd();
    issue(1, 2, 1, 4);
    tick(); check("clamp_hi", int'(count), 4);
    finish_cmd();

    // 6: reset mid-run at count 7
    issue(1, 10, 0, 15);
    while (count != 4'd7 && busy) tick();
    check("t6_at7", int'(count), 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_count", int'(count), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_ready", int'(cmd_ready), 1);
    check("t6_done", int'(done), 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_updown_sweep_ctrl
